// File: rtl/octal_psram_responder.sv
// Octal PSRAM target model for the board-facing side of the bus.
// Decodes the DDR instruction, address and mode-register beats coming from a
// controller, services writes and reads against an internal 16-bit word
// array, and returns read data with a DQS strobe. iClk runs at twice the
// PSRAM clock, so every clock cycle with CE low is one bus beat.
//
// Ports:
//   iClk        fabric clock (one beat per cycle)
//   iRst_N      synchronous active-low reset
//   iPSRAM_CE   chip select, active low
//   iPSRAM_RST  device RESET#, active low
//   iDQ         command/address/write-data byte
//   iDQS_DM     write data mask (1 = skip this byte)
//   oDQ         read data byte
//   oDQ_OE      drive enable for oDQ
//   oDQS        read strobe
//   oDQS_OE     drive enable for oDQS
//   oBusy       command in progress
//   oCmd_Err    one-cycle pulse on an illegal instruction
module octal_psram_responder #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 5,
  parameter int WR_LAT = 1
) (
  input  logic       iClk,
  input  logic       iRst_N,
  input  logic       iPSRAM_CE,
  input  logic       iPSRAM_RST,
  input  logic [7:0] iDQ,
  input  logic       iDQS_DM,
  output logic [7:0] oDQ,
  output logic       oDQ_OE,
  output logic       oDQS,
  output logic       oDQS_OE,
  output logic       oBusy,
  output logic       oCmd_Err
);

  localparam int R0    = 4 + 2 * RD_LAT;
  localparam int W0    = 6 + 2 * (WR_LAT - 1);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_LAT, S_RDATA, S_MRW, S_GRES, S_ERR
  } state_t;

  state_t            state_q;
  logic [7:0]        cnt_q;      // beat counter, saturates
  logic              ph_q;       // parity of the current beat (1 = odd)
  logic [7:0]        inst_q;
  logic              is_rd_q;
  logic              is_mr_q;
  logic              gres_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        ma_q;
  logic [7:0]        mr_q [0:8];
  logic [15:0]       mem_q [DEPTH];

  logic [7:0]        dq_q;
  logic              dq_oe_q;
  logic              dqs_q;
  logic              dqs_oe_q;
  logic              busy_q;
  logic              err_q;

  logic              rst_all;
  logic [ADDR_W+7:0] addr_cat;
  logic [ADDR_W-1:0] addr_shift;
  logic [ADDR_W-1:0] addr_use;
  logic [7:0]        ma_use;
  logic [8:0]        nxt_beat;
  logic              in_rd;
  logic              rd_data;
  logic [15:0]       rd_word;
  logic [7:0]        mr_val;
  logic [7:0]        rd_byte;
  logic              wr_en;

  function automatic logic legal_cmd(input logic [7:0] c);
    case (c)
      8'h00, 8'h80, 8'h20, 8'hA0, 8'h40, 8'hC0, 8'hFF: legal_cmd = 1'b1;
      default:                                         legal_cmd = 1'b0;
    endcase
  endfunction

  function automatic logic mr_writable(input logic [7:0] ma);
    mr_writable = (ma == 8'd0) || ((ma >= 8'd3) && (ma <= 8'd8));
  endfunction

  function automatic logic [7:0] mr_reset_val(input int idx);
    case (idx)
      1:       mr_reset_val = 8'h0D;
      2:       mr_reset_val = 8'h93;
      default: mr_reset_val = 8'h00;
    endcase
  endfunction

  // Outputs describe the beat after the one being sampled, so the address
  // and MA byte arriving on beat 5 are forwarded straight from iDQ; this is
  // what lets the array be read one cycle ahead without a bubble at R0.
  always_comb begin
    rst_all    = ~iRst_N | ~iPSRAM_RST;
    addr_cat   = {addr_q, iDQ};
    addr_shift = addr_cat[ADDR_W-1:0];
    addr_use   = (state_q == S_ADDR) ? addr_shift : addr_q;
    ma_use     = (state_q == S_ADDR) ? iDQ : ma_q;
    nxt_beat   = {1'b0, cnt_q} + 9'd1;
    in_rd      = is_rd_q && (state_q inside {S_ADDR, S_LAT, S_RDATA});
    rd_data    = in_rd && ((state_q == S_RDATA) || (nxt_beat >= 9'(R0)));
    rd_word    = mem_q[addr_use];
    mr_val     = (ma_use <= 8'd8) ? mr_q[ma_use[3:0]] : 8'h00;
    // Odd current beat means the next beat is even and carries the high byte.
    rd_byte    = is_mr_q ? mr_val : (ph_q ? rd_word[15:8] : rd_word[7:0]);
    wr_en      = ~rst_all & ~iPSRAM_CE & (state_q == S_WDATA)
               & (cnt_q >= 8'(W0)) & ~iDQS_DM;
  end

  // Array contents survive every kind of reset.
  always_ff @(posedge iClk) begin
    if (wr_en) begin
      if (!ph_q) mem_q[addr_q][15:8] <= iDQ;
      else       mem_q[addr_q][7:0]  <= iDQ;
    end
  end

  always_ff @(posedge iClk) begin
    if (rst_all) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ph_q     <= 1'b0;
      inst_q   <= '0;
      is_rd_q  <= 1'b0;
      is_mr_q  <= 1'b0;
      gres_q   <= 1'b0;
      addr_q   <= '0;
      ma_q     <= '0;
      for (int i = 0; i < 9; i++) mr_q[i] <= mr_reset_val(i);
      dq_q     <= '0;
      dq_oe_q  <= 1'b0;
      dqs_q    <= 1'b0;
      dqs_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (iPSRAM_CE) begin
      // Enables drop on the very edge CE is seen high; busy lingers one cycle.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ph_q     <= 1'b0;
      dq_q     <= '0;
      dq_oe_q  <= 1'b0;
      dqs_q    <= 1'b0;
      dqs_oe_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= (state_q != S_IDLE);
      gres_q   <= 1'b0;
      if (gres_q) begin
        for (int i = 0; i < 9; i++) mr_q[i] <= mr_reset_val(i);
      end
    end else begin
      if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      ph_q     <= ~ph_q;
      busy_q   <= 1'b1;
      err_q    <= 1'b0;
      dq_q     <= '0;
      dq_oe_q  <= 1'b0;
      dqs_q    <= 1'b0;
      dqs_oe_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          inst_q  <= iDQ;
          state_q <= S_CMD;
        end
        S_CMD: begin
          if ((iDQ == inst_q) && legal_cmd(iDQ)) begin
            is_rd_q <= (iDQ == 8'h00) || (iDQ == 8'h20) || (iDQ == 8'h40);
            is_mr_q <= (iDQ == 8'h40) || (iDQ == 8'hC0);
            gres_q  <= (iDQ == 8'hFF);
            state_q <= (iDQ == 8'hFF) ? S_GRES : S_ADDR;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end
        end
        S_ADDR: begin
          addr_q <= addr_shift;
          ma_q   <= iDQ;
          if (cnt_q == 8'd5) begin
            if (is_rd_q)      state_q <= rd_data ? S_RDATA : S_LAT;
            else if (is_mr_q) state_q <= S_MRW;
            else              state_q <= S_WDATA;
          end
        end
        S_LAT: begin
          if (rd_data) state_q <= S_RDATA;
        end
        S_WDATA: begin
          if ((cnt_q >= 8'(W0)) && ph_q) addr_q <= addr_q + ADDR_W'(1);
        end
        S_MRW: begin
          if ((cnt_q == 8'd6) && mr_writable(ma_q)) mr_q[ma_q[3:0]] <= iDQ;
        end
        default: ;
      endcase

      if (in_rd) begin
        dqs_oe_q <= (nxt_beat >= 9'(R0 - 2));
        if (rd_data) begin
          dq_oe_q <= 1'b1;
          dqs_q   <= ph_q;
          dq_q    <= rd_byte;
          if (!is_mr_q && !ph_q) addr_q <= addr_use + ADDR_W'(1);
        end
      end
    end
  end

  assign oDQ      = dq_q;
  assign oDQ_OE   = dq_oe_q;
  assign oDQS     = dqs_q;
  assign oDQS_OE  = dqs_oe_q;
  assign oBusy    = busy_q;
  assign oCmd_Err = err_q;

endmodule

// File: tb/tb_octal_psram_responder.sv
module tb_octal_psram_responder;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int R0     = 14;
  localparam int OBS_N  = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       prst;
  logic [7:0] dq;
  logic       dm;
  logic [7:0] o_dq_w;
  logic       o_dqoe_w, o_dqs_w, o_dqsoe_w, o_busy_w, o_err_w;

  octal_psram_responder #(.ADDR_W(ADDR_W), .RD_LAT(5), .WR_LAT(1)) dut (
    .iClk(clk), .iRst_N(rst_n), .iPSRAM_CE(ce), .iPSRAM_RST(prst),
    .iDQ(dq), .iDQS_DM(dm), .oDQ(o_dq_w), .oDQ_OE(o_dqoe_w), .oDQS(o_dqs_w),
    .oDQS_OE(o_dqsoe_w), .oBusy(o_busy_w), .oCmd_Err(o_err_w)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [15:0] mem_m [DEPTH];
  logic [7:0]  mr_m  [0:8];

  // Stimulus buffers and per-beat observations (index = beat number)
  logic [7:0] wbuf [0:2047];
  logic       wdm  [0:2047];
  logic [7:0] o_dq    [0:OBS_N-1];
  logic       o_dqoe  [0:OBS_N-1];
  logic       o_dqs   [0:OBS_N-1];
  logic       o_dqsoe [0:OBS_N-1];
  logic       o_busy  [0:OBS_N-1];
  logic       o_err   [0:OBS_N-1];

  function automatic void m_write(input int base, input int nbytes);
    for (int j = 0; j < nbytes; j++) begin
      int w;
      w = (base + j / 2) % DEPTH;
      if (!wdm[j]) begin
        if (j % 2 == 0) mem_m[w][15:8] = wbuf[j];
        else            mem_m[w][7:0]  = wbuf[j];
      end
    end
  endfunction

  function automatic logic [7:0] m_byte(input int base, input int j);
    logic [15:0] w;
    w = mem_m[(base + j / 2) % DEPTH];
    return (j % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  function automatic void mr_m_reset();
    for (int i = 0; i < 9; i++) mr_m[i] = 8'h00;
  endfunction

  function automatic logic [7:0] mr_exp(input int ma);
    if (ma == 1) return 8'h0D;
    if (ma == 2) return 8'h93;
    if (ma <= 8) return mr_m[ma];
    return 8'h00;
  endfunction

  function automatic void mr_m_write(input int ma, input logic [7:0] d);
    if (ma == 0 || (ma >= 3 && ma <= 8)) mr_m[ma] = d;
  endfunction

  // One CE-low transaction of nbeats beats, then CE high for a few cycles.
  // Outputs are captured at the negedge preceding the edge that samples beat k.
  task automatic txn(input logic [7:0] i0, input logic [7:0] i1,
                     input logic [31:0] a, input int nbeats);
    for (int k = 0; k < nbeats + 3; k++) begin
      @(negedge clk);
      if (k < OBS_N) begin
        o_dq[k]    = o_dq_w;
        o_dqoe[k]  = o_dqoe_w;
        o_dqs[k]   = o_dqs_w;
        o_dqsoe[k] = o_dqsoe_w;
        o_busy[k]  = o_busy_w;
        o_err[k]   = o_err_w;
      end
      if (k < nbeats) begin
        ce = 1'b0;
        case (k)
          0:       dq = i0;
          1:       dq = i1;
          2:       dq = a[31:24];
          3:       dq = a[23:16];
          4:       dq = a[15:8];
          5:       dq = a[7:0];
          default: dq = wbuf[k - 6];
        endcase
        dm = (k >= 6) ? wdm[k - 6] : 1'b0;
      end else begin
        ce = 1'b1;
        dq = 8'h00;
        dm = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce    = 1'b0;
    dq    = 8'h80;
    repeat (3) @(negedge clk);
    total++; if (o_dq_w !== 8'h00)  begin bad++; $display("FAIL rst_dq got %h want 00", o_dq_w); end
    total++; if (o_dqoe_w !== 1'b0) begin bad++; $display("FAIL rst_dqoe got %b want 0", o_dqoe_w); end
    total++; if (o_dqs_w !== 1'b0)  begin bad++; $display("FAIL rst_dqs got %b want 0", o_dqs_w); end
    total++; if (o_dqsoe_w !== 1'b0) begin bad++; $display("FAIL rst_dqsoe got %b want 0", o_dqsoe_w); end
    total++; if (o_busy_w !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", o_busy_w); end
    total++; if (o_err_w !== 1'b0)  begin bad++; $display("FAIL rst_err got %b want 0", o_err_w); end
    ce    = 1'b1;
    dq    = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mr_m_reset();
  endtask

  // Fill the whole array with one long burst so every word has a known value.
  task automatic init_mem();
    for (int j = 0; j < 2048; j++) begin
      wbuf[j] = 8'($urandom);
      wdm[j]  = 1'b0;
    end
    txn(8'hA0, 8'hA0, {22'($urandom), 10'd0}, 6 + 2048);
    m_write(0, 2048);
  endtask

  task automatic test_mr_read_waveform();
    txn(8'h40, 8'h40, {24'($urandom), 8'd1}, 18);
    for (int k = 0; k < 21; k++) begin
      logic e_dqsoe, e_dqoe, e_dqs, e_busy;
      logic [7:0] e_dq;
      e_dqsoe = (k >= 12 && k <= 18);
      e_dqoe  = (k >= 14 && k <= 18);
      e_dqs   = (k >= 14 && k <= 18 && (k % 2 == 0));
      e_dq    = (k >= 14 && k <= 18) ? 8'h0D : 8'h00;
      e_busy  = (k >= 1 && k <= 19);
      total++; if (o_dqsoe[k] !== e_dqsoe) begin bad++; $display("FAIL mrrd_dqsoe beat %0d got %b want %b", k, o_dqsoe[k], e_dqsoe); end
      total++; if (o_dqoe[k] !== e_dqoe) begin bad++; $display("FAIL mrrd_dqoe beat %0d got %b want %b", k, o_dqoe[k], e_dqoe); end
      total++; if (o_dqs[k] !== e_dqs) begin bad++; $display("FAIL mrrd_dqs beat %0d got %b want %b", k, o_dqs[k], e_dqs); end
      total++; if (o_dq[k] !== e_dq) begin bad++; $display("FAIL mrrd_dq beat %0d got %h want %h", k, o_dq[k], e_dq); end
      total++; if (o_busy[k] !== e_busy) begin bad++; $display("FAIL mrrd_busy beat %0d got %b want %b", k, o_busy[k], e_busy); end
      total++; if (o_err[k] !== 1'b0) begin bad++; $display("FAIL mrrd_err beat %0d got %b want 0", k, o_err[k]); end
    end
  endtask

  task automatic test_sync_write_read();
    logic [7:0] exp [4];
    exp = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    for (int j = 0; j < 4; j++) begin wbuf[j] = exp[j]; wdm[j] = 1'b0; end
    txn(8'h80, 8'h80, 32'h0000_0010, 10);
    m_write(16, 4);
    txn(8'h00, 8'h00, 32'h0000_0010, 17);
    for (int j = 0; j < 4; j++) begin
      total++; if (o_dq[R0 + j] !== exp[j]) begin bad++; $display("FAIL wr_rd beat %0d got %h want %h", R0 + j, o_dq[R0 + j], exp[j]); end
    end
  endtask

  task automatic test_dm();
    wbuf[0] = 8'hFF; wbuf[1] = 8'hFF; wdm[0] = 1'b0; wdm[1] = 1'b0;
    txn(8'h80, 8'h80, 32'h0000_0020, 8);
    m_write(32, 2);
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wdm[0] = 1'b0; wdm[1] = 1'b1;
    txn(8'h80, 8'h80, 32'h0000_0020, 8);
    m_write(32, 2);
    txn(8'h00, 8'h00, 32'h0000_0020, 15);
    total++; if (o_dq[R0] !== 8'hA5) begin bad++; $display("FAIL dm_hi got %h want a5", o_dq[R0]); end
    total++; if (o_dq[R0 + 1] !== 8'hFF) begin bad++; $display("FAIL dm_lo got %h want ff", o_dq[R0 + 1]); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int j = 0; j < 4; j++) begin wbuf[j] = exp[j]; wdm[j] = 1'b0; end
    txn(8'hA0, 8'hA0, {22'($urandom), 10'h3FF}, 10);
    m_write(DEPTH - 1, 4);
    txn(8'h20, 8'h20, {22'($urandom), 10'h3FF}, 17);
    for (int j = 0; j < 4; j++) begin
      total++; if (o_dq[R0 + j] !== exp[j]) begin bad++; $display("FAIL wrap_rd beat %0d got %h want %h", R0 + j, o_dq[R0 + j], exp[j]); end
    end
    txn(8'h00, 8'h00, 32'h0000_0000, 15);
    total++; if (o_dq[R0] !== 8'h33) begin bad++; $display("FAIL wrap_w0_hi got %h want 33", o_dq[R0]); end
    total++; if (o_dq[R0 + 1] !== 8'h44) begin bad++; $display("FAIL wrap_w0_lo got %h want 44", o_dq[R0 + 1]); end
  endtask

  task automatic test_mr_write_gres();
    wbuf[0] = 8'h5C; wdm[0] = 1'b0;
    txn(8'hC0, 8'hC0, {24'($urandom), 8'd4}, 7);
    mr_m_write(4, 8'h5C);
    wbuf[0] = 8'h00;
    txn(8'hC0, 8'hC0, {24'($urandom), 8'd2}, 7);
    mr_m_write(2, 8'h00);
    txn(8'h40, 8'h40, 32'd4, 14);
    total++; if (o_dq[R0] !== 8'h5C) begin bad++; $display("FAIL mr4_before got %h want 5c", o_dq[R0]); end
    txn(8'h40, 8'h40, 32'd2, 14);
    total++; if (o_dq[R0] !== 8'h93) begin bad++; $display("FAIL mr2_before got %h want 93", o_dq[R0]); end
    txn(8'hFF, 8'hFF, 32'd0, 2);
    mr_m_reset();
    txn(8'h40, 8'h40, 32'd4, 14);
    total++; if (o_dq[R0] !== 8'h00) begin bad++; $display("FAIL mr4_after got %h want 00", o_dq[R0]); end
    txn(8'h40, 8'h40, 32'd2, 14);
    total++; if (o_dq[R0] !== 8'h93) begin bad++; $display("FAIL mr2_after got %h want 93", o_dq[R0]); end
    txn(8'h00, 8'h00, 32'h0000_0010, 15);
    total++; if (o_dq[R0] !== m_byte(16, 0)) begin bad++; $display("FAIL gres_keep_hi got %h want %h", o_dq[R0], m_byte(16, 0)); end
    total++; if (o_dq[R0 + 1] !== m_byte(16, 1)) begin bad++; $display("FAIL gres_keep_lo got %h want %h", o_dq[R0 + 1], m_byte(16, 1)); end
  endtask

  task automatic test_bad_cmd();
    for (int t = 0; t < 3; t++) begin
      logic [7:0] i0, i1;
      int a;
      if (t == 0)      begin i0 = 8'h80; i1 = 8'h00; end
      else if (t == 1) begin i0 = 8'h55; i1 = 8'h55; end
      else begin i0 = 8'($urandom); i1 = i0 ^ 8'($urandom_range(1, 255)); end
      a = $urandom_range(0, DEPTH - 1);
      for (int j = 0; j < 4; j++) begin wbuf[j] = 8'($urandom); wdm[j] = 1'b0; end
      txn(i0, i1, 32'(a), 10);
      for (int k = 0; k < 13; k++) begin
        total++; if (o_err[k] !== (k == 2)) begin bad++; $display("FAIL err_pulse t%0d beat %0d got %b want %b", t, k, o_err[k], (k == 2)); end
        total++; if ((o_dqoe[k] | o_dqsoe[k]) !== 1'b0) begin bad++; $display("FAIL err_oe t%0d beat %0d got %b%b want 00", t, k, o_dqoe[k], o_dqsoe[k]); end
      end
      txn(8'h00, 8'h00, 32'(a), 17);
      for (int j = 0; j < 4; j++) begin
        total++; if (o_dq[R0 + j] !== m_byte(a, j)) begin bad++; $display("FAIL err_nowrite t%0d byte %0d got %h want %h", t, j, o_dq[R0 + j], m_byte(a, j)); end
      end
    end
  endtask

  task automatic test_abort();
    int a;
    a = $urandom_range(0, DEPTH - 1);
    txn(8'h20, 8'h20, 32'(a), 15);
    total++; if (o_dq[14] !== m_byte(a, 0)) begin bad++; $display("FAIL abort_b14 got %h want %h", o_dq[14], m_byte(a, 0)); end
    total++; if (o_dq[15] !== m_byte(a, 1)) begin bad++; $display("FAIL abort_b15 got %h want %h", o_dq[15], m_byte(a, 1)); end
    total++; if (o_dqoe[15] !== 1'b1) begin bad++; $display("FAIL abort_oe15 got %b want 1", o_dqoe[15]); end
    total++; if (o_dqoe[16] !== 1'b0) begin bad++; $display("FAIL abort_oe16 got %b want 0", o_dqoe[16]); end
    total++; if (o_dqsoe[16] !== 1'b0) begin bad++; $display("FAIL abort_dqsoe16 got %b want 0", o_dqsoe[16]); end
    total++; if (o_busy[16] !== 1'b1) begin bad++; $display("FAIL abort_busy16 got %b want 1", o_busy[16]); end
    total++; if (o_busy[17] !== 1'b0) begin bad++; $display("FAIL abort_busy17 got %b want 0", o_busy[17]); end
    txn(8'h00, 8'h00, 32'(a), 14);
    txn(8'h00, 8'h00, 32'(a), 15);
    total++; if (o_dq[14] !== m_byte(a, 0)) begin bad++; $display("FAIL abort_after_hi got %h want %h", o_dq[14], m_byte(a, 0)); end
    total++; if (o_dq[15] !== m_byte(a, 1)) begin bad++; $display("FAIL abort_after_lo got %h want %h", o_dq[15], m_byte(a, 1)); end
  endtask

  task automatic test_psram_rst();
    logic [7:0] d;
    d = 8'($urandom_range(1, 255));
    wbuf[0] = d; wdm[0] = 1'b0;
    txn(8'hC0, 8'hC0, 32'd5, 7);
    mr_m_write(5, d);
    txn(8'h40, 8'h40, 32'd5, 14);
    total++; if (o_dq[R0] !== mr_exp(5)) begin bad++; $display("FAIL prst_before got %h want %h", o_dq[R0], mr_exp(5)); end
    @(negedge clk);
    prst = 1'b0; ce = 1'b0; dq = 8'hC0;
    repeat (3) @(negedge clk);
    total++; if (o_busy_w !== 1'b0) begin bad++; $display("FAIL prst_busy got %b want 0", o_busy_w); end
    total++; if ((o_dqoe_w | o_dqsoe_w) !== 1'b0) begin bad++; $display("FAIL prst_oe got %b%b want 00", o_dqoe_w, o_dqsoe_w); end
    ce = 1'b1; dq = 8'h00;
    @(negedge clk);
    prst = 1'b1;
    @(negedge clk);
    mr_m_reset();
    txn(8'h40, 8'h40, 32'd5, 14);
    total++; if (o_dq[R0] !== 8'h00) begin bad++; $display("FAIL prst_after got %h want 00", o_dq[R0]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int op, a, n, ma;
      op = $urandom_range(0, 5);
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 4, DEPTH - 1) : $urandom_range(0, DEPTH - 1);
      n  = $urandom_range(1, 8);
      ma = $urandom_range(0, 10);
      case (op)
        0, 1: begin
          for (int j = 0; j < n; j++) begin wbuf[j] = 8'($urandom); wdm[j] = ($urandom_range(0, 3) == 0); end
          txn((op == 0) ? 8'h80 : 8'hA0, (op == 0) ? 8'h80 : 8'hA0, {22'($urandom), 10'(a)}, 6 + n);
          m_write(a, n);
        end
        2, 3: begin
          txn((op == 2) ? 8'h00 : 8'h20, (op == 2) ? 8'h00 : 8'h20, {22'($urandom), 10'(a)}, R0 - 1 + n);
          for (int j = 0; j < n; j++) begin
            total++; if (o_dq[R0 + j] !== m_byte(a, j)) begin bad++; $display("FAIL rnd_rd it%0d addr %0d byte %0d got %h want %h", it, a, j, o_dq[R0 + j], m_byte(a, j)); end
            total++; if (o_dqoe[R0 + j] !== 1'b1) begin bad++; $display("FAIL rnd_rd_oe it%0d byte %0d got %b want 1", it, j, o_dqoe[R0 + j]); end
          end
        end
        4: begin
          wbuf[0] = 8'($urandom); wdm[0] = 1'b0;
          txn(8'hC0, 8'hC0, {24'($urandom), 8'(ma)}, 7);
          mr_m_write(ma, wbuf[0]);
        end
        default: begin
          txn(8'h40, 8'h40, {24'($urandom), 8'(ma)}, R0 + 1);
          total++; if (o_dq[R0] !== mr_exp(ma)) begin bad++; $display("FAIL rnd_mr it%0d ma %0d got %h want %h", it, ma, o_dq[R0], mr_exp(ma)); end
          total++; if (o_dq[R0 + 1] !== mr_exp(ma)) begin bad++; $display("FAIL rnd_mr2 it%0d ma %0d got %h want %h", it, ma, o_dq[R0 + 1], mr_exp(ma)); end
        end
      endcase
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b1;
    prst  = 1'b1;
    dq    = 8'h00;
    dm    = 1'b0;
    test_reset();
    test_mr_read_waveform();
    init_mem();
    test_sync_write_read();
    test_dm();
    test_wrap();
    test_mr_write_gres();
    test_bad_cmd();
    test_abort();
    test_psram_rst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/octal_psram_responder.md
# octal_psram_responder

Synthesizable Octal PSRAM target that answers the controller-side command stream: it decodes the DDR instruction, address and mode-register beats, and services writes and reads against an internal word array. Reads are returned with the DQS strobe. The block runs on one fabric clock at twice the PSRAM clock rate, so each DDR half-cycle is exactly one iClk cycle (one "beat"). It sits on the board-facing side of the bus and is used as a loopback target in hardware bring-up and as the device model in controller regression.

## Interface
- ADDR_W, 10: word-address width; array depth is 2^ADDR_W 16-bit words.
- RD_LAT, 5: read latency in PSRAM clocks.
- WR_LAT, 1: write latency in PSRAM clocks.
- iClk  in  1  fabric clock, 2x PSRAM clock; one bus beat per cycle.
- iRst_N  in  1  reset, synchronous, active-low.
- iPSRAM_CE  in  1  chip select, active low.
- iPSRAM_RST  in  1  device RESET#, active low.
- iDQ  in  8  address/data bus from the controller.
- iDQS_DM  in  1  data mask during writes (1 = do not write this byte).
- oDQ  out  8  read data to the bus.
- oDQ_OE  out  1  drive enable for oDQ.
- oDQS  out  1  read strobe.
- oDQS_OE  out  1  drive enable for oDQS.
- oBusy  out  1  high while CE is low and a command is in progress.
- oCmd_Err  out  1  one-cycle pulse on an illegal command.

## Operation
- Beat counter B clears on the cycle CE is sampled high and increments each cycle while CE is low. Beat 0 is the first low-CE cycle. Even beats are rising-edge beats; odd beats are falling-edge beats.
- Beats 0 and 1 carry the instruction.
  - Both beats must be equal and be one of: 00 (sync read), 80 (sync write), 20 (burst read), A0 (burst write), 40 (MR read), C0 (MR write), FF (global reset).
  - Anything else: pulse oCmd_Err at beat 2, then state ERR and ignore the bus until CE goes high.
- Memory commands: beats 2–5 carry A[31:24], A[23:16], A[15:8], A[7:0]. The word address is A[ADDR_W-1:0]; upper bits are ignored.
- MR commands: beats 2–4 are don't-care; beat 5 carries MA.
- State machine: IDLE -> CMD (beats 0–1) -> ADDR (beats 2–5), then:
  - -> WDATA for writes;
  - -> LAT -> RDATA for reads;
  - -> MRW for MR write;
  - -> ERR.
  - CE high in any state -> IDLE on the next cycle.
- Write data starts at beat W0 = 6 + 2*(WR_LAT-1).
  - Each beat writes one byte: even beat = high byte [15:8], odd beat = low byte [7:0].
  - A byte is written only when iDQS_DM = 0.
  - The word address increments after each odd beat.
- Read data starts at beat R0 = 4 + 2*RD_LAT (14 at default).
  - Even beat drives the high byte; odd beat drives the low byte.
  - The address increments after each odd beat.
- Address wrap: past 2^ADDR_W-1 the address wraps to 0. Sync and burst commands behave identically.
- Mode registers:
  - MR0 and MR4 are read/write, reset value 00.
  - MR1 is read-only 0D; MR2 is read-only 93.
  - MA 3, 5–8 are read/write, reset value 00.
  - MR write: the byte on beat 6 is stored to MR[MA]. Writes to read-only or undefined MA are dropped.
  - MR read: MR[MA] is driven on every data beat from R0 onward. Undefined MA reads 00.
- Global reset (FF): at CE rise, all MRs return to reset values. Array contents are kept.
- iPSRAM_RST low: immediately go to IDLE, drop all OEs, and reset MRs. Commands are ignored while it is low.
- iRst_N low: same effect as iPSRAM_RST low. The array is not cleared.
- Read and write on the same address never overlap, since CE serializes commands.

## Timing
- Reset values: oDQ=00, oDQ_OE=0, oDQS=0, oDQS_OE=0, oBusy=0, oCmd_Err=0.
- All outputs are registered.
  - Data for beat k is presented on the cycle that the beat counter equals k.
  - The array is read one cycle ahead so that there is no bubble at R0.
- oDQS_OE rises at beat R0-2 with oDQS=0, giving a one-PSRAM-clock preamble.
- From R0, oDQS = 1 on even beats and 0 on odd beats. oDQ_OE rises at R0.
- CE high: oDQ_OE and oDQS_OE fall on the same cycle CE is sampled high (combinational clear of the enable register input). No postamble.
- Partial word on abort: bytes already written stay written. A read aborted mid-word has no side effects.
- oBusy = 1 from beat 0 until the cycle after CE rises.

## Test plan
- Reset, then MR read of MA=1 at RD_LAT=5 -> oDQS_OE rises at beat 12; oDQ=0D on beats 14, 15, 16…; oDQS toggles 1,0,1….
- Sync write 80/80, address 0000_0010, data 12 34 AB CD, DM all 0; then sync read of 0000_0010 -> beats 14–17 return 12 34 AB CD.
- Write A5 5A at address 0000_0020 with DM=1 on the low byte, over an existing word FFFF -> readback returns A5 FF.
- Burst write starting at address 2^ADDR_W-1 with data 11 22 33 44 -> word 3FF = 1122 and word 000 = 3344.
- MR write MA=4 with data 5C, MR write MA=2 with data 00, then global reset FF -> MR4 reads 5C before the reset and 00 after it; MR2 reads 93 throughout.
- Instruction 80/00 -> oCmd_Err pulses at beat 2; no array change; no OE activity. Separately, CE rising mid-read at beat 15 -> oDQ_OE falls that cycle and oBusy clears the next cycle.
